decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- ID stage of the 5-stage MIPS pipeline; consumes the IF/ID latch contents (next-PC, instruction) produced by fetch.
- Holds the 32x32 register file and the main control decoder, and raises the load-use stall request back to fetch.
- Registers all results into the ID/EX latch.
- Also receives the EX/MEM branch-taken squash and the MEM/WB writeback.

Parameters:
- NREGS, 32: register file depth (index width fixed at 5).
- RESET_VAL, 32'h0: reset value of every register-file entry and ID/EX data field.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- if_id_npc  in  32  PC+4 from the IF/ID latch
- if_id_instr  in  32  instruction from the IF/ID latch
- ex_mem_pc_src  in  1  branch taken in EX/MEM; squash the instruction now in ID
- mem_wb_regwrite  in  1  writeback enable
- mem_wb_write_reg  in  5  writeback register index
- mem_wb_write_data  in  32  writeback data
- hazard_stall  out  1  combinational load-use stall request to fetch (hold PC and IF/ID)
- id_ex_wb  out  2  {regwrite, memtoreg}
- id_ex_m  out  3  {branch, memread, memwrite}
- id_ex_ex  out  4  {regdst, aluop[1:0], alusrc}
- id_ex_npc  out  32  registered if_id_npc
- id_ex_readdat1  out  32  rs value
- id_ex_readdat2  out  32  rt value
- id_ex_sign_ext  out  32  sign-extended instr[15:0]
- id_ex_instr_2016  out  5  rt field
- id_ex_instr_1511  out  5  rd field

Behaviour:
- Reset (rst=0, async): all id_ex_* outputs become 0 and all register-file entries become RESET_VAL. hazard_stall is derived from id_ex_m and is therefore 0 during reset.
- Latency: 1 cycle. Fields are decoded from if_id_instr in cycle N and appear on id_ex_* after edge N+1.
- Decode by opcode instr[31:26]; control values are given as wb/m/ex:
  - 0x00 R-type: 10 / 000 / 1100
  - 0x23 lw: 11 / 010 / 0001
  - 0x2B sw: 00 / 001 / 0001 (memtoreg is don't-care, driven 0)
  - 0x04 beq: 00 / 100 / 0010
  - Any other opcode: all control 0 (bubble). Data fields still load.
- Register file reads:
  - Index 0 reads 0 and writes to index 0 are ignored.
  - Write-through bypass: when mem_wb_regwrite=1, mem_wb_write_reg!=0 and it equals rs (or rt), the readdat captures mem_wb_write_data in the same cycle.
  - The array write occurs on the same edge.
- Sign extension: id_ex_sign_ext = {{16{instr[15]}}, instr[15:0]}.
- hazard_stall = id_ex_m[1] & ((id_ex_instr_2016 == instr[25:21]) | (id_ex_instr_2016 == instr[20:16])).
  - Both source fields are compared for every opcode; conservative stalls are accepted.
  - A load targeting $0 still stalls.
- Stall cycle: id_ex_wb/m/ex load 0 (bubble). All data fields load normally. Fetch must hold IF/ID, so the same instruction is re-decoded next cycle.
- Flush (ex_mem_pc_src=1): id_ex_wb/m/ex load 0. Data fields load normally.
- Simultaneous flush and stall produce a single bubble. hazard_stall is still asserted as computed, and fetch's redirect takes priority on its side.
- The register-file write proceeds regardless of stall or flush.
- Reset asserted mid-operation clears the pipeline and register file immediately, with no dependence on clk.

Test Plan:
- Reset: hold rst=0 with clk running and random inputs -> all id_ex_* = 0 and hazard_stall = 0. Release, then decode add $3,$1,$2 (0x00221820) -> readdat1 = readdat2 = 0, wb = 10, ex = 1100, instr_1511 = 3.
- Writeback then read: write $1 = 0x0000_0005 and $2 = 0xFFFF_FFF0 via the mem_wb ports, then decode 0x00221820 -> readdat1 = 5, readdat2 = 0xFFFF_FFF0. In the same cycle write $1 = 7 while decoding -> readdat1 = 7 (bypass). Write $0 = 0x1234 -> $0 still reads 0.
- lw/sw/beq: decode lw $4,-4($1) (0x8C24FFFC) -> wb = 11, m = 010, ex = 0001, sign_ext = 0xFFFF_FFFC, instr_2016 = 4. Decode sw (0xAC240008) -> m = 001, sign_ext = 8. Decode beq (0x10220003) -> m = 100, ex = 0010. Decode opcode 0x3F -> all control 0.
- Load-use: lw $4 followed by add $5,$4,$1 (0x00812820) -> hazard_stall = 1 for one cycle and a bubble enters ID/EX. Re-decoding the add -> hazard_stall = 0 and add control issues.
- Flush: ex_mem_pc_src=1 while decoding add -> next id_ex control = 0 while id_ex_npc still updates. Flush together with a load-use stall -> exactly one bubble.
- Async reset mid-stream: drop rst between clk edges -> outputs clear before the next edge and $1 reads 0 afterwards.

Source files
------------

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage
//  Purpose  : MIPS ID stage with register file, main control decode and
//             load-use stall detection, registered into the ID/EX latch.
//  Revision : 1.0
// ============================================================================
module decode_stage #(
  parameter int          NREGS     = 32,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_id_npc,
  input  logic [31:0] if_id_instr,
  input  logic        ex_mem_pc_src,
  input  logic        mem_wb_regwrite,
  input  logic [4:0]  mem_wb_write_reg,
  input  logic [31:0] mem_wb_write_data,
  output logic        hazard_stall,
  output logic [1:0]  id_ex_wb,
  output logic [2:0]  id_ex_m,
  output logic [3:0]  id_ex_ex,
  output logic [31:0] id_ex_npc,
  output logic [31:0] id_ex_readdat1,
  output logic [31:0] id_ex_readdat2,
  output logic [31:0] id_ex_sign_ext,
  output logic [4:0]  id_ex_instr_2016,
  output logic [4:0]  id_ex_instr_1511
);

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;

  logic [31:0] r_regs [NREGS];

  logic [1:0]  r_wb;
  logic [2:0]  r_m;
  logic [3:0]  r_ex;
  logic [31:0] r_npc;
  logic [31:0] r_readdat1;
  logic [31:0] r_readdat2;
  logic [31:0] r_sign_ext;
  logic [4:0]  r_rt;
  logic [4:0]  r_rd;

  logic [5:0]  w_opcode;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_sign_ext;
  logic [31:0] w_read1;
  logic [31:0] w_read2;
  logic        w_wr_en;
  logic        w_bubble;
  logic        w_stall;
  logic [1:0]  w_wb;
  logic [2:0]  w_m;
  logic [3:0]  w_ex;

  assign w_opcode   = if_id_instr[31:26];
  assign w_rs       = if_id_instr[25:21];
  assign w_rt       = if_id_instr[20:16];
  assign w_rd       = if_id_instr[15:11];
  assign w_sign_ext = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
  assign w_wr_en    = mem_wb_regwrite && (mem_wb_write_reg != 5'd0);

  // Write-through: a same-cycle writeback is visible to the read ports.
  always_comb begin
    w_read1 = 32'h0;
    w_read2 = 32'h0;
    if (w_rs != 5'd0) begin
      w_read1 = (w_wr_en && mem_wb_write_reg == w_rs) ? mem_wb_write_data : r_regs[w_rs];
    end
    if (w_rt != 5'd0) begin
      w_read2 = (w_wr_en && mem_wb_write_reg == w_rt) ? mem_wb_write_data : r_regs[w_rt];
    end
  end

  // Both source fields compared regardless of opcode; over-stalling is harmless.
  assign w_stall  = r_m[1] && ((r_rt == w_rs) || (r_rt == w_rt));
  assign w_bubble = w_stall || ex_mem_pc_src;

  always_comb begin
    w_wb = 2'b00;
    w_m  = 3'b000;
    w_ex = 4'b0000;
    case (w_opcode)
      c_OP_RTYPE: begin w_wb = 2'b10; w_m = 3'b000; w_ex = 4'b1100; end
      c_OP_LW:    begin w_wb = 2'b11; w_m = 3'b010; w_ex = 4'b0001; end
      c_OP_SW:    begin w_wb = 2'b00; w_m = 3'b001; w_ex = 4'b0001; end
      c_OP_BEQ:   begin w_wb = 2'b00; w_m = 3'b100; w_ex = 4'b0010; end
      default:    begin w_wb = 2'b00; w_m = 3'b000; w_ex = 4'b0000; end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else if (w_wr_en) begin
      r_regs[mem_wb_write_reg] <= mem_wb_write_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb       <= 2'b00;
      r_m        <= 3'b000;
      r_ex       <= 4'b0000;
      r_npc      <= RESET_VAL;
      r_readdat1 <= RESET_VAL;
      r_readdat2 <= RESET_VAL;
      r_sign_ext <= RESET_VAL;
      r_rt       <= 5'd0;
      r_rd       <= 5'd0;
    end else begin
      r_wb       <= w_bubble ? 2'b00   : w_wb;
      r_m        <= w_bubble ? 3'b000  : w_m;
      r_ex       <= w_bubble ? 4'b0000 : w_ex;
      r_npc      <= if_id_npc;
      r_readdat1 <= w_read1;
      r_readdat2 <= w_read2;
      r_sign_ext <= w_sign_ext;
      r_rt       <= w_rt;
      r_rd       <= w_rd;
    end
  end

  assign hazard_stall     = w_stall;
  assign id_ex_wb         = r_wb;
  assign id_ex_m          = r_m;
  assign id_ex_ex         = r_ex;
  assign id_ex_npc        = r_npc;
  assign id_ex_readdat1   = r_readdat1;
  assign id_ex_readdat2   = r_readdat2;
  assign id_ex_sign_ext   = r_sign_ext;
  assign id_ex_instr_2016 = r_rt;
  assign id_ex_instr_1511 = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_stage
//  Purpose  : Directed self-checking bench for decode_stage.
//  Revision : 1.0
// ============================================================================
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] if_id_npc;
  logic [31:0] if_id_instr;
  logic        ex_mem_pc_src;
  logic        mem_wb_regwrite;
  logic [4:0]  mem_wb_write_reg;
  logic [31:0] mem_wb_write_data;
  logic        hazard_stall;
  logic [1:0]  id_ex_wb;
  logic [2:0]  id_ex_m;
  logic [3:0]  id_ex_ex;
  logic [31:0] id_ex_npc;
  logic [31:0] id_ex_readdat1;
  logic [31:0] id_ex_readdat2;
  logic [31:0] id_ex_sign_ext;
  logic [4:0]  id_ex_instr_2016;
  logic [4:0]  id_ex_instr_1511;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] c_ADD   = 32'h0022_1820;  // add $3,$1,$2
  localparam logic [31:0] c_ADD0  = 32'h0000_1820;  // add $3,$0,$0
  localparam logic [31:0] c_LW    = 32'h8C24_FFFC;  // lw  $4,-4($1)
  localparam logic [31:0] c_LW0   = 32'h8C20_FFFC;  // lw  $0,-4($1)
  localparam logic [31:0] c_SW    = 32'hAC24_0008;
  localparam logic [31:0] c_BEQ   = 32'h1022_0003;
  localparam logic [31:0] c_BAD   = 32'hFC00_0000;
  localparam logic [31:0] c_ADDU  = 32'h0081_2820;  // add $5,$4,$1

  decode_stage dut (
    .clk               (clk),
    .rst               (rst),
    .if_id_npc         (if_id_npc),
    .if_id_instr       (if_id_instr),
    .ex_mem_pc_src     (ex_mem_pc_src),
    .mem_wb_regwrite   (mem_wb_regwrite),
    .mem_wb_write_reg  (mem_wb_write_reg),
    .mem_wb_write_data (mem_wb_write_data),
    .hazard_stall      (hazard_stall),
    .id_ex_wb          (id_ex_wb),
    .id_ex_m           (id_ex_m),
    .id_ex_ex          (id_ex_ex),
    .id_ex_npc         (id_ex_npc),
    .id_ex_readdat1    (id_ex_readdat1),
    .id_ex_readdat2    (id_ex_readdat2),
    .id_ex_sign_ext    (id_ex_sign_ext),
    .id_ex_instr_2016  (id_ex_instr_2016),
    .id_ex_instr_1511  (id_ex_instr_1511)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctrl(input string tag, input logic [1:0] wb, input logic [2:0] m,
                            input logic [3:0] ex);
    check({tag, ".wb"}, {30'd0, id_ex_wb}, {30'd0, wb});
    check({tag, ".m"},  {29'd0, id_ex_m},  {29'd0, m});
    check({tag, ".ex"}, {28'd0, id_ex_ex}, {28'd0, ex});
  endtask

  initial begin
    rst               = 1'b0;
    ex_mem_pc_src     = 1'b0;
    mem_wb_regwrite   = 1'b0;
    mem_wb_write_reg  = 5'd0;
    mem_wb_write_data = 32'h0;
    if_id_npc         = 32'h0;
    if_id_instr       = 32'h0;

    // Reset with random activity on the inputs
    for (int i = 0; i < 4; i++) begin
      if_id_npc         = $urandom;
      if_id_instr       = $urandom;
      ex_mem_pc_src     = 1'($urandom);
      mem_wb_regwrite   = 1'($urandom);
      mem_wb_write_reg  = 5'($urandom);
      mem_wb_write_data = $urandom;
      tick();
    end
    check_ctrl("rst", 2'b00, 3'b000, 4'b0000);
    check("rst.npc", id_ex_npc, 32'h0);
    check("rst.rd1", id_ex_readdat1, 32'h0);
    check("rst.sext", id_ex_sign_ext, 32'h0);
    check("rst.rt", {27'd0, id_ex_instr_2016}, 32'h0);
    check("rst.stall", {31'd0, hazard_stall}, 32'h0);

    ex_mem_pc_src   = 1'b0;
    mem_wb_regwrite = 1'b0;
    rst             = 1'b1;
    if_id_instr     = c_ADD;
    if_id_npc       = 32'h4;
    tick();
    check_ctrl("add0", 2'b10, 3'b000, 4'b1100);
    check("add0.rd1", id_ex_readdat1, 32'h0);
    check("add0.rd2", id_ex_readdat2, 32'h0);
    check("add0.rd", {27'd0, id_ex_instr_1511}, 32'd3);
    check("add0.npc", id_ex_npc, 32'h4);

    // Writebacks, then read back
    if_id_instr = 32'h0;
    mem_wb_regwrite = 1'b1; mem_wb_write_reg = 5'd1; mem_wb_write_data = 32'h0000_0005;
    tick();
    mem_wb_write_reg = 5'd2; mem_wb_write_data = 32'hFFFF_FFF0;
    tick();
    mem_wb_regwrite = 1'b0;
    if_id_instr = c_ADD;
    tick();
    check("wb.rd1", id_ex_readdat1, 32'h5);
    check("wb.rd2", id_ex_readdat2, 32'hFFFF_FFF0);

    mem_wb_regwrite = 1'b1; mem_wb_write_reg = 5'd1; mem_wb_write_data = 32'h7;
    tick();
    check("byp.rd1", id_ex_readdat1, 32'h7);
    check("byp.rd2", id_ex_readdat2, 32'hFFFF_FFF0);

    mem_wb_write_reg = 5'd0; mem_wb_write_data = 32'h1234;
    if_id_instr = c_ADD0;
    tick();
    check("r0.byp", id_ex_readdat1, 32'h0);
    mem_wb_regwrite = 1'b0;
    tick();
    check("r0.rd1", id_ex_readdat1, 32'h0);

    // lw / sw / beq / unknown opcode
    if_id_instr = c_LW; if_id_npc = 32'h10;
    tick();
    check_ctrl("lw", 2'b11, 3'b010, 4'b0001);
    check("lw.sext", id_ex_sign_ext, 32'hFFFF_FFFC);
    check("lw.rt", {27'd0, id_ex_instr_2016}, 32'd4);
    check("lw.rd1", id_ex_readdat1, 32'h7);
    if_id_instr = 32'h0;
    #1 check("nomatch.stall", {31'd0, hazard_stall}, 32'h0);
    tick();
    if_id_instr = c_SW;
    tick();
    check_ctrl("sw", 2'b00, 3'b001, 4'b0001);
    check("sw.sext", id_ex_sign_ext, 32'h8);
    if_id_instr = c_BEQ;
    tick();
    check_ctrl("beq", 2'b00, 3'b100, 4'b0010);
    if_id_instr = c_BAD; if_id_npc = 32'h20;
    tick();
    check_ctrl("bad", 2'b00, 3'b000, 4'b0000);
    check("bad.npc", id_ex_npc, 32'h20);

    // Load-use stall
    if_id_instr = c_LW;
    tick();
    if_id_instr = c_ADDU;
    #1 check("lu.stall", {31'd0, hazard_stall}, 32'h1);
    tick();
    check_ctrl("lu.bubble", 2'b00, 3'b000, 4'b0000);
    check("lu.rd", {27'd0, id_ex_instr_1511}, 32'd5);
    check("lu.stall2", {31'd0, hazard_stall}, 32'h0);
    tick();
    check_ctrl("lu.issue", 2'b10, 3'b000, 4'b1100);

    // Load to $0 still stalls
    if_id_instr = c_LW0;
    tick();
    if_id_instr = 32'h0;
    #1 check("lw0.stall", {31'd0, hazard_stall}, 32'h1);
    tick();

    // Flush
    if_id_instr = c_ADD; if_id_npc = 32'h100; ex_mem_pc_src = 1'b1;
    tick();
    ex_mem_pc_src = 1'b0;
    check_ctrl("fl", 2'b00, 3'b000, 4'b0000);
    check("fl.npc", id_ex_npc, 32'h100);

    // Flush coincident with load-use stall: a single bubble
    if_id_instr = c_LW; if_id_npc = 32'h104;
    tick();
    if_id_instr = c_ADDU; ex_mem_pc_src = 1'b1;
    #1 check("fs.stall", {31'd0, hazard_stall}, 32'h1);
    tick();
    ex_mem_pc_src = 1'b0;
    check_ctrl("fs.bubble", 2'b00, 3'b000, 4'b0000);
    tick();
    check_ctrl("fs.issue", 2'b10, 3'b000, 4'b1100);

    // Async reset between edges
    if_id_instr = c_ADD; if_id_npc = 32'h200;
    tick();
    check("ar.pre", id_ex_readdat1, 32'h7);
    #2 rst = 1'b0;
    #1;
    check_ctrl("ar", 2'b00, 3'b000, 4'b0000);
    check("ar.npc", id_ex_npc, 32'h0);
    check("ar.rd1", id_ex_readdat1, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    check("ar.r1", id_ex_readdat1, 32'h0);
    check_ctrl("ar.add", 2'b10, 3'b000, 4'b1100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
